// File: rtl/dtb_pkg.sv
// Shared trace-buffer types: packer FSM states, output word metadata, nt clamp.
package dtb_pkg;

  localparam int TRB_WIDTH      = 64;
  localparam int TRB_MAX_TRACES = 8;

  // Metadata fields are sized for TRB_WIDTH-bit words; wider words need a
  // larger TRB_WIDTH here.
  localparam int META_POS_W  = $clog2(TRB_WIDTH);
  localparam int META_FILL_W = META_POS_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } packer_state_t;

  typedef struct packed {
    logic                   trig;
    logic [META_POS_W-1:0]  trig_pos;
    logic [META_FILL_W-1:0] fill;
  } trace_word_meta_t;

  // Requested log2 lane count, limited to what the hardware has.
  function automatic int unsigned clamp_nt(input int unsigned nt, input int unsigned max_nt);
    return (nt > max_nt) ? max_nt : nt;
  endfunction

endpackage

// File: rtl/trace_word_reg.sv
// One-entry ready/valid output register for a packed word plus metadata.
// A load that cannot be accepted is dropped and flagged on drop_o.
module trace_word_reg
  import dtb_pkg::*;
#(
  parameter int WORD_WIDTH = TRB_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  trace_word_meta_t      meta_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output trace_word_meta_t      meta_o,
  output logic                  drop_o
);

  logic                  valid_q;
  logic [WORD_WIDTH-1:0] word_q;
  trace_word_meta_t      meta_q;
  logic                  accept;

  // Slot is free when empty or when the current word leaves this cycle.
  assign accept = !valid_q || ready_i;
  assign drop_o = load_i && !accept;

  // Load / hold / release of the single entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      meta_q  <= '0;
    end else if (load_i && accept) begin
      valid_q <= 1'b1;
      word_q  <= word_i;
      meta_q  <= meta_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign meta_o  = meta_q;

endmodule

// File: rtl/trace_packer.sv
// Packs 1..MAX_TRACES trace lanes per sample into WORD_WIDTH-bit words, LSB
// first, with trigger tagging, partial-word flush and sticky overflow.
module trace_packer
  import dtb_pkg::*;
#(
  parameter int WORD_WIDTH = TRB_WIDTH,
  parameter int MAX_TRACES = TRB_MAX_TRACES,
  parameter int NT_W       = $clog2($clog2(MAX_TRACES) + 1)
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  input  logic                          ENABLE_I,
  input  logic [NT_W-1:0]               NUM_TRACES_I,
  input  logic                          TRACE_VALID_I,
  input  logic [MAX_TRACES-1:0]         TRACE_I,
  input  logic                          TRIG_I,
  input  logic                          FLUSH_I,
  input  logic                          WORD_READY_I,
  output logic                          WORD_VALID_O,
  output logic [WORD_WIDTH-1:0]         WORD_O,
  output logic                          WORD_TRIG_O,
  output logic [$clog2(WORD_WIDTH)-1:0] WORD_TRIG_POS_O,
  output logic [$clog2(WORD_WIDTH):0]   WORD_FILL_O,
  output logic                          OVERFLOW_O
);

  localparam int          POS_W  = $clog2(WORD_WIDTH);
  localparam int          FILL_W = POS_W + 1;
  localparam int unsigned MAX_NT = $clog2(MAX_TRACES);

  packer_state_t         state_q, state_d;
  logic                  en_q;
  logic [NT_W-1:0]       nt_q, nt_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [WORD_WIDTH-1:0] sword_q, sword_d;
  logic                  trig_q, trig_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  ovf_q, ovf_d;

  logic                  rise;
  logic [FILL_W-1:0]     lanes;
  logic [MAX_TRACES-1:0] lane_mask;
  logic [WORD_WIDTH-1:0] sample_sh;

  logic                  emit;
  logic [WORD_WIDTH-1:0] emit_word;
  trace_word_meta_t      emit_meta;
  trace_word_meta_t      out_meta;
  logic                  drop;

  assign rise      = ENABLE_I && !en_q;
  assign lanes     = FILL_W'(1) << nt_q;
  // Shifting by MAX_TRACES wraps to zero, so the full-width mask is all ones.
  assign lane_mask = (MAX_TRACES'(1) << lanes) - MAX_TRACES'(1);
  assign sample_sh = WORD_WIDTH'(TRACE_I & lane_mask) << fill_q;

  // State, shift word, fill/trigger tracking and sticky overflow.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      nt_q    <= '0;
      fill_q  <= '0;
      sword_q <= '0;
      trig_q  <= 1'b0;
      pos_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= ENABLE_I;
      nt_q    <= nt_d;
      fill_q  <= fill_d;
      sword_q <= sword_d;
      trig_q  <= trig_d;
      pos_q   <= pos_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: sample packing first, then completion or flush of the word.
  always_comb begin
    state_d   = state_q;
    nt_d      = nt_q;
    fill_d    = fill_q;
    sword_d   = sword_q;
    trig_d    = trig_q;
    pos_d     = pos_q;
    ovf_d     = ovf_q || drop;
    emit      = 1'b0;
    emit_word = '0;
    emit_meta = '0;
    case (state_q)
      IDLE: begin
        fill_d  = '0;
        sword_d = '0;
        trig_d  = 1'b0;
        pos_d   = '0;
        if (rise) begin
          state_d = PACK;
          nt_d    = NT_W'(clamp_nt(32'(NUM_TRACES_I), MAX_NT));
          ovf_d   = 1'b0;
        end
      end
      PACK: begin
        if (!ENABLE_I) begin
          state_d = IDLE;
          fill_d  = '0;
          sword_d = '0;
          trig_d  = 1'b0;
          pos_d   = '0;
        end else begin
          if (TRACE_VALID_I) begin
            sword_d = sword_q | sample_sh;
            fill_d  = fill_q + lanes;
            if (TRIG_I && !trig_q) begin
              trig_d = 1'b1;
              pos_d  = fill_q[POS_W-1:0];
            end
          end
          if (fill_d == FILL_W'(WORD_WIDTH) || (FLUSH_I && fill_d != '0)) begin
            emit               = 1'b1;
            emit_word          = sword_d;
            emit_meta.trig     = trig_d;
            emit_meta.trig_pos = META_POS_W'(pos_d);
            emit_meta.fill     = META_FILL_W'(fill_d);
            fill_d             = '0;
            sword_d            = '0;
            trig_d             = 1'b0;
            pos_d              = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  trace_word_reg #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_word_reg (
    .clk_i  (CLK_I),
    .rst_i  (RST_I),
    .load_i (emit),
    .word_i (emit_word),
    .meta_i (emit_meta),
    .ready_i(WORD_READY_I),
    .valid_o(WORD_VALID_O),
    .word_o (WORD_O),
    .meta_o (out_meta),
    .drop_o (drop)
  );

  assign WORD_TRIG_O     = out_meta.trig;
  assign WORD_TRIG_POS_O = POS_W'(out_meta.trig_pos);
  assign WORD_FILL_O     = FILL_W'(out_meta.fill);
  assign OVERFLOW_O      = ovf_q;

endmodule

// File: doc/trace_packer.md
# trace_packer

Parametrised trace-word packer for the streaming trace buffer's FPGA-facing capture path. It packs 1 to MAX_TRACES trace lanes per sample into WORD_WIDTH-bit words, LSB first. Each word carries trigger-position metadata and is emitted on a ready/valid stream towards the trace memory. Compared with the fixed packing in the current buffer, it adds:
- a runtime-selectable lane count,
- flushing of partial words with a fill count,
- per-word trigger tagging,
- sticky overflow detection under back-pressure.

## Interface
Parameters:
- WORD_WIDTH, default TRB_WIDTH (64): packed word width; power of two, multiple of MAX_TRACES.
- MAX_TRACES, default TRB_MAX_TRACES (8): physical trace lanes; power of two.
- NT_W, default $clog2($clog2(MAX_TRACES)+1): width of the lane-count select.

Ports:
- CLK_I  in  1  sole clock. One clock domain; reset is synchronous and active-high.
- RST_I  in  1  synchronous, active-high reset.
- ENABLE_I  in  1  capture enable; NUM_TRACES_I is latched on its rising edge.
- NUM_TRACES_I  in  NT_W  log2 of lanes per sample; values above $clog2(MAX_TRACES) are clamped.
- TRACE_VALID_I  in  1  TRACE_I/TRIG_I carry a sample this cycle.
- TRACE_I  in  MAX_TRACES  sample; only lanes [2**nt-1:0] are used.
- TRIG_I  in  1  trigger flag, qualified by TRACE_VALID_I.
- FLUSH_I  in  1  emit the current partial word.
- WORD_READY_I  in  1  downstream accepts a word.
- WORD_VALID_O  out  1  word available.
- WORD_O  out  WORD_WIDTH  packed word.
- WORD_TRIG_O  out  1  a trigger fell inside this word.
- WORD_TRIG_POS_O  out  $clog2(WORD_WIDTH)  bit offset of the triggering sample's lane 0.
- WORD_FILL_O  out  $clog2(WORD_WIDTH)+1  number of valid bits in WORD_O.
- OVERFLOW_O  out  1  sticky: a completed word was dropped.

## Operation
States:
- IDLE: ENABLE_I low. No packing. Partial data is discarded. A pending output word stays until handshaked.
- PACK: entered on the ENABLE_I rising edge. On entry:
  - nt latched from NUM_TRACES_I (clamped); lanes = 2**nt.
  - fill = 0; OVERFLOW_O cleared.
- PACK -> IDLE when ENABLE_I is low.
- NUM_TRACES_I is ignored while in PACK.

Packing and word completion:
- Each valid sample writes TRACE_I[j] to shift-word bit fill+j, for j < lanes; then fill += lanes.
- The word completes when fill+lanes == WORD_WIDTH. The completed word moves to the output register with fill = WORD_WIDTH, and the internal fill resets to 0.

Trigger tagging:
- The first valid sample with TRIG_I=1 in a word sets trig = 1 and pos = the fill value before that sample.
- Later triggers in the same word are ignored.
- TRIG_I without TRACE_VALID_I is ignored.

Flush:
- FLUSH_I in PACK with fill > 0 emits the partial word. Bits at and above fill are zero, and WORD_FILL_O = fill.
- FLUSH_I with fill == 0 does nothing.
- A sample and a flush in the same cycle: the sample is packed first, then the word is flushed.

Output register (one entry):
- A word is loaded if the register is empty, or if WORD_READY_I is high that cycle.
- Otherwise the new word is dropped and OVERFLOW_O is set. OVERFLOW_O clears only on RST_I or the next ENABLE_I rising edge.

## Timing
- Reset values: WORD_VALID_O=0, WORD_O=0, WORD_TRIG_O=0, WORD_TRIG_POS_O=0, WORD_FILL_O=0, OVERFLOW_O=0. State = IDLE, fill = 0, nt = 0.
- RST_I asserted mid-word clears everything within one cycle. No partial word is emitted.
- Latency: a sample completing a word in cycle n gives WORD_VALID_O=1 in cycle n+1. A flush behaves the same.
- Handshake:
  - A transfer happens on a cycle with WORD_VALID_O && WORD_READY_I.
  - WORD_O and its metadata stay stable while WORD_VALID_O is high and WORD_READY_I is low.
  - WORD_VALID_O does not depend combinationally on WORD_READY_I.
- Full throughput: a word completing in the same cycle as a transfer loads with no bubble, giving back-to-back valid words.
- Sustained rate: at 8 lanes, one word per WORD_WIDTH/8 samples.

## Structure
- DTB_PKG gains:
  - packer_state_t (IDLE, PACK);
  - struct trace_word_meta_t {trig, trig_pos, fill};
  - the clamp function for nt.
- TRB_WIDTH and TRB_MAX_TRACES in DTB_PKG supply the parameter defaults.
- Sub-module: trace_word_reg, the one-entry ready/valid output register carrying word plus meta, which reports drop to raise overflow.

## Test plan
WORD_WIDTH=64, MAX_TRACES=8, WORD_READY_I=1 unless stated.
- nt=3, 8 valid samples 0x00..0x07 -> one word 0x0706050403020100, FILL=64, TRIG=0, valid on the cycle after the 8th sample.
- nt=0, 64 samples alternating 1,0, TRIG_I on sample index 10 and again on index 20 -> word 0x5555555555555555, TRIG=1, POS=10.
- nt=3, WORD_READY_I=0, 16 samples -> first word held stable, second word dropped, OVERFLOW_O=1. OVERFLOW_O stays 1 after ready rises; it clears on the next ENABLE_I rising edge.
- nt=3, samples 0xAA, 0xBB, then 0xCC together with FLUSH_I -> word 0x0000000000CCBBAA, FILL=24. A subsequent FLUSH_I alone emits nothing.
- nt=3, 4 samples, then RST_I for 1 cycle, then re-enable and send 8 samples 0x10..0x17 -> no word before reset-exit, then 0x1716151413121110.
- nt=2, ready held high, 32 contiguous samples -> two words on consecutive valid cycles, OVERFLOW_O=0. NUM_TRACES_I changed mid-PACK has no effect.
